// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, the per-axis timing record and its validity rule.
package vga_pkg;

    localparam int TF_W = 16;

    localparam int X_W_DEF      = 11;
    localparam int Y_W_DEF      = 10;
    localparam int H_ACTIVE_DEF = 1024;
    localparam int H_TOTAL_DEF  = 1328;
    localparam int HS_START_DEF = 1048;
    localparam int HS_END_DEF   = 1184;
    localparam int V_ACTIVE_DEF = 768;
    localparam int V_TOTAL_DEF  = 806;
    localparam int VS_START_DEF = 771;
    localparam int VS_END_DEF   = 777;

    typedef struct packed {
        logic [TF_W-1:0] active;
        logic [TF_W-1:0] total;
        logic [TF_W-1:0] sync_start;
        logic [TF_W-1:0] sync_end;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } timing_set_t;

    function automatic axis_timing_t make_axis(input int active, input int total,
                                               input int sync_start, input int sync_end);
        axis_timing_t t;
        t.active     = TF_W'(active);
        t.total      = TF_W'(total);
        t.sync_start = TF_W'(sync_start);
        t.sync_end   = TF_W'(sync_end);
        return t;
    endfunction

    // Active region must sit strictly inside the line, sync window after it and non-empty.
    function automatic logic axis_timing_ok(input axis_timing_t t);
        return (t.active < t.total) && (t.active <= t.sync_start) &&
               (t.sync_start < t.sync_end) && (t.sync_end <= t.total) &&
               (t.total >= TF_W'(2));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping position counter plus combinational active/sync decode.
// Position advances by one on each step; wraps to zero at total-1.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  axis_timing_t timing,
    output logic [W-1:0] pos,
    output logic         at_last,
    output logic         at_first,
    output logic         in_active,
    output logic         in_sync
);

    logic [TF_W-1:0] pos_ext;

    assign pos_ext   = TF_W'(pos);
    // >= rather than == so a counter can never run past the end of the axis.
    assign at_last   = pos_ext >= (timing.total - TF_W'(1));
    assign at_first  = (pos == '0);
    assign in_active = pos_ext < timing.active;
    assign in_sync   = (pos_ext >= timing.sync_start) && (pos_ext < timing.sync_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (step) begin
            pos <= at_last ? '0 : pos + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-reconfigurable VGA raster timing; outputs registered one cycle after the counters.
// New configs are shadowed and committed at frame wrap; cfg_ready stays low while one is pending.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_END   = HS_END_DEF,
    parameter bit HS_POL   = 1'b0,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_END   = VS_END_DEF,
    parameter bit VS_POL   = 1'b0
) (
    input  logic           clk75MHz,
    input  logic           reset,
    input  logic           en,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [X_W-1:0] cfg_h_active,
    input  logic [X_W-1:0] cfg_h_total,
    input  logic [X_W-1:0] cfg_hs_start,
    input  logic [X_W-1:0] cfg_hs_end,
    input  logic [Y_W-1:0] cfg_v_active,
    input  logic [Y_W-1:0] cfg_v_total,
    input  logic [Y_W-1:0] cfg_vs_start,
    input  logic [Y_W-1:0] cfg_vs_end,
    output logic           cfg_err,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           hsync,
    output logic           vsync,
    output logic           visible,
    output logic           line_start,
    output logic           frame_start
);

    localparam timing_set_t RESET_SET = '{
        h: make_axis(H_ACTIVE, H_TOTAL, HS_START, HS_END),
        v: make_axis(V_ACTIVE, V_TOTAL, VS_START, VS_END)
    };

    timing_set_t    act_set;
    timing_set_t    shadow_set;
    timing_set_t    cfg_set;
    logic           pending;
    logic           cfg_fire;
    logic           cfg_ok;
    logic           frame_wrap;

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           x_last, x_first, x_act, x_sync;
    logic           y_last, y_first, y_act, y_sync;

    assign cfg_set.h = '{active:     TF_W'(cfg_h_active),
                         total:      TF_W'(cfg_h_total),
                         sync_start: TF_W'(cfg_hs_start),
                         sync_end:   TF_W'(cfg_hs_end)};
    assign cfg_set.v = '{active:     TF_W'(cfg_v_active),
                         total:      TF_W'(cfg_v_total),
                         sync_start: TF_W'(cfg_vs_start),
                         sync_end:   TF_W'(cfg_vs_end)};

    assign cfg_ready  = !pending;
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign cfg_ok     = axis_timing_ok(cfg_set.h) && axis_timing_ok(cfg_set.v);
    assign frame_wrap = en && x_last && y_last;

    vga_axis_counter #(.W(X_W)) u_x_axis (
        .clk       (clk75MHz),
        .rst       (reset),
        .step      (en),
        .timing    (act_set.h),
        .pos       (x),
        .at_last   (x_last),
        .at_first  (x_first),
        .in_active (x_act),
        .in_sync   (x_sync)
    );

    vga_axis_counter #(.W(Y_W)) u_y_axis (
        .clk       (clk75MHz),
        .rst       (reset),
        .step      (en && x_last),
        .timing    (act_set.v),
        .pos       (y),
        .at_last   (y_last),
        .at_first  (y_first),
        .in_active (y_act),
        .in_sync   (y_sync)
    );

    // Accept and commit are mutually exclusive: accept needs !pending, commit needs pending.
    always_ff @(posedge clk75MHz or posedge reset) begin
        if (reset) begin
            act_set    <= RESET_SET;
            shadow_set <= RESET_SET;
            pending    <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (frame_wrap && pending) begin
                act_set <= shadow_set;
                pending <= 1'b0;
            end else if (cfg_fire) begin
                if (cfg_ok) begin
                    shadow_set <= cfg_set;
                    pending    <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk75MHz or posedge reset) begin
        if (reset) begin
            pix_x       <= '0;
            pix_y       <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            visible     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            pix_x       <= x;
            pix_y       <= y;
            hsync       <= x_sync ? HS_POL : ~HS_POL;
            vsync       <= y_sync ? VS_POL : ~VS_POL;
            visible     <= x_act && y_act;
            line_start  <= x_first;
            frame_start <= x_first && y_first;
        end else begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            visible     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: per-scenario tasks against a linear-position reference model.
module tb_vga_timing_gen;

    localparam int X_W       = 11;
    localparam int Y_W       = 10;
    localparam int VW        = X_W + Y_W + 7;
    localparam bit HS_POL    = 1'b0;
    localparam bit VS_POL    = 1'b0;
    // Short vertical timing so whole frames fit in a practical run.
    localparam int V_ACT_T   = 10;
    localparam int V_TOT_T   = 14;
    localparam int VS_S_T    = 11;
    localparam int VS_E_T    = 13;
    localparam int DEF_FRAME = 1328 * V_TOT_T;

    logic           clk75MHz = 1'b0;
    logic           reset, en, cfg_valid, cfg_ready, cfg_err;
    logic [X_W-1:0] cfg_h_active, cfg_h_total, cfg_hs_start, cfg_hs_end;
    logic [Y_W-1:0] cfg_v_active, cfg_v_total, cfg_vs_start, cfg_vs_end;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           hsync, vsync, visible, line_start, frame_start;

    always #5 clk75MHz = ~clk75MHz;

    vga_timing_gen #(
        .V_ACTIVE (V_ACT_T), .V_TOTAL (V_TOT_T), .VS_START (VS_S_T), .VS_END (VS_E_T)
    ) dut (
        .clk75MHz     (clk75MHz),     .reset        (reset),
        .en           (en),           .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),    .cfg_h_active (cfg_h_active),
        .cfg_h_total  (cfg_h_total),  .cfg_hs_start (cfg_hs_start),
        .cfg_hs_end   (cfg_hs_end),   .cfg_v_active (cfg_v_active),
        .cfg_v_total  (cfg_v_total),  .cfg_vs_start (cfg_vs_start),
        .cfg_vs_end   (cfg_vs_end),   .cfg_err      (cfg_err),
        .pix_x        (pix_x),        .pix_y        (pix_y),
        .hsync        (hsync),        .vsync        (vsync),
        .visible      (visible),      .line_start   (line_start),
        .frame_start  (frame_start)
    );

    // Reference state: timing arrays are {active, total, start, end}; position is linear in the frame.
    int th[4], tv[4], sh[4], sv[4];
    int m_pos;
    bit m_pend;
    int e_x, e_y;
    bit e_hs, e_vs, e_vis, e_ls, e_fs, e_err;

    int n_chk = 0;
    int n_pass = 0;
    int mism;
    logic [VW-1:0] first_got, first_want;

    function automatic bit axis_ok(input int a, input int t, input int s, input int e);
        return (a < t) && (a <= s) && (s < e) && (e <= t) && (t >= 2);
    endfunction

    task automatic model_reset();
        th = '{1024, 1328, 1048, 1184};
        tv = '{V_ACT_T, V_TOT_T, VS_S_T, VS_E_T};
        sh = th;
        sv = tv;
        m_pos = 0;
        m_pend = 1'b0;
        e_x = 0; e_y = 0;
        e_hs = !HS_POL; e_vs = !VS_POL;
        e_vis = 1'b0; e_ls = 1'b0; e_fs = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_edge();
        bit was_pend;
        int x, y;
        was_pend = m_pend;
        if (reset) begin
            model_reset();
            return;
        end
        e_err = 1'b0;
        if (cfg_valid && !m_pend) begin
            if (axis_ok(int'(cfg_h_active), int'(cfg_h_total), int'(cfg_hs_start), int'(cfg_hs_end)) &&
                axis_ok(int'(cfg_v_active), int'(cfg_v_total), int'(cfg_vs_start), int'(cfg_vs_end))) begin
                sh = '{int'(cfg_h_active), int'(cfg_h_total), int'(cfg_hs_start), int'(cfg_hs_end)};
                sv = '{int'(cfg_v_active), int'(cfg_v_total), int'(cfg_vs_start), int'(cfg_vs_end)};
                m_pend = 1'b1;
            end else begin
                e_err = 1'b1;
            end
        end
        if (en) begin
            x = m_pos % th[1];
            y = m_pos / th[1];
            e_x = x;
            e_y = y;
            e_vis = (x < th[0]) && (y < tv[0]);
            e_hs = (x >= th[2] && x < th[3]) ? HS_POL : !HS_POL;
            e_vs = (y >= tv[2] && y < tv[3]) ? VS_POL : !VS_POL;
            e_ls = (x == 0);
            e_fs = (m_pos == 0);
            m_pos++;
            if (m_pos == th[1] * tv[1]) begin
                m_pos = 0;
                if (was_pend) begin
                    th = sh;
                    tv = sv;
                    m_pend = 1'b0;
                end
            end
        end else begin
            e_hs = !HS_POL; e_vs = !VS_POL;
            e_vis = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
        end
    endtask

    function automatic logic [VW-1:0] obs_vec();
        return {pix_x, pix_y, hsync, vsync, visible, line_start, frame_start, cfg_ready, cfg_err};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {X_W'(e_x), Y_W'(e_y), e_hs, e_vs, e_vis, e_ls, e_fs, !m_pend, e_err};
    endfunction

    // One clock: model the coming edge, then sample at the following falling edge.
    task automatic step();
        model_edge();
        @(negedge clk75MHz);
        if (obs_vec() !== exp_vec()) begin
            if (mism == 0) begin
                first_got = obs_vec();
                first_want = exp_vec();
            end
            mism++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        cfg_h_active = '0; cfg_h_total = '0; cfg_hs_start = '0; cfg_hs_end = '0;
        cfg_v_active = '0; cfg_v_total = '0; cfg_vs_start = '0; cfg_vs_end = '0;
        #2;
        n_chk++;
        if ({pix_x, pix_y} !== '0) $display("FAIL reset_pos: got %0d,%0d want 0,0", pix_x, pix_y);
        else n_pass++;
        n_chk++;
        if ({hsync, vsync} !== {!HS_POL, !VS_POL}) $display("FAIL reset_sync: got %b%b want %b%b", hsync, vsync, !HS_POL, !VS_POL);
        else n_pass++;
        n_chk++;
        if ({visible, line_start, frame_start, cfg_err} !== 4'b0000)
            $display("FAIL reset_flags: got %b%b%b%b want 0000", visible, line_start, frame_start, cfg_err);
        else n_pass++;
        n_chk++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cfg_ready);
        else n_pass++;
        model_reset();
        @(negedge clk75MHz);
    endtask

    task automatic test_default_frame();
        int period, hs_low, hs_first, vis_line0, vis_all, vs_first, vs_lines;
        period = 0; hs_low = 0; hs_first = -1; vis_line0 = 0; vis_all = 0; vs_first = -1; vs_lines = 0;
        mism = 0;
        reset = 1'b0; en = 1'b1;
        step();
        n_chk++;
        if ({pix_x, pix_y, visible, line_start, frame_start} !== (X_W + Y_W + 3)'(3'b111))
            $display("FAIL first_cycle: got x=%0d y=%0d vis=%b ls=%b fs=%b want 0 0 1 1 1",
                     pix_x, pix_y, visible, line_start, frame_start);
        else n_pass++;
        do begin
            if (pix_y == 0 && hsync == HS_POL) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(pix_x);
            end
            if (pix_y == 0 && visible) vis_line0++;
            if (visible) vis_all++;
            if (line_start && vsync == VS_POL) begin
                vs_lines++;
                if (vs_first < 0) vs_first = int'(pix_y);
            end
            step();
            period++;
        end while (!frame_start && period <= 2 * DEF_FRAME);
        n_chk++;
        if (period != DEF_FRAME) $display("FAIL frame_period: got %0d want %0d", period, DEF_FRAME);
        else n_pass++;
        n_chk++;
        if (hs_low != 136) $display("FAIL hsync_width: got %0d want 136", hs_low);
        else n_pass++;
        n_chk++;
        if (hs_first != 1048) $display("FAIL hsync_start: got %0d want 1048", hs_first);
        else n_pass++;
        n_chk++;
        if (vis_line0 != 1024) $display("FAIL visible_line: got %0d want 1024", vis_line0);
        else n_pass++;
        n_chk++;
        if (vis_all != 1024 * V_ACT_T) $display("FAIL visible_frame: got %0d want %0d", vis_all, 1024 * V_ACT_T);
        else n_pass++;
        n_chk++;
        if (vs_first != VS_S_T || vs_lines != VS_E_T - VS_S_T)
            $display("FAIL vsync_lines: got first %0d count %0d want %0d %0d", vs_first, vs_lines, VS_S_T, VS_E_T - VS_S_T);
        else n_pass++;
        n_chk++;
        if (mism != 0) $display("FAIL trace_default: %0d cycles differ, first got %h want %h", mism, first_got, first_want);
        else n_pass++;
    endtask

    task automatic test_cfg_mid_frame();
        int period, hs_low, hs_first, vis_all, rdy_cnt, rdy_x, rdy_y, spins;
        period = 0; hs_low = 0; hs_first = -1; vis_all = 0; rdy_cnt = 0; rdy_x = -1; rdy_y = -1; spins = 0;
        mism = 0;
        repeat ($urandom_range(100, 6000)) step();
        cfg_h_active = 11'd640; cfg_h_total = 11'd800; cfg_hs_start = 11'd656; cfg_hs_end = 11'd752;
        cfg_v_active = 10'd8;   cfg_v_total = 10'd12;  cfg_vs_start = 10'd9;   cfg_vs_end = 10'd10;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        n_chk++;
        if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) $display("FAIL cfg_accept: got rdy=%b err=%b want 0 0", cfg_ready, cfg_err);
        else n_pass++;
        cfg_hs_end = 11'd600;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        n_chk++;
        if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) $display("FAIL cfg_busy_ignored: got rdy=%b err=%b want 0 0", cfg_ready, cfg_err);
        else n_pass++;
        while (!frame_start && spins < 2 * DEF_FRAME) begin
            if (cfg_ready) begin
                rdy_cnt++;
                rdy_x = int'(pix_x);
                rdy_y = int'(pix_y);
            end
            step();
            spins++;
        end
        n_chk++;
        if (rdy_cnt != 1 || rdy_x != 1327 || rdy_y != V_TOT_T - 1)
            $display("FAIL cfg_ready_frame_end: got %0d high cycles last at %0d,%0d want 1 at 1327,%0d", rdy_cnt, rdy_x, rdy_y, V_TOT_T - 1);
        else n_pass++;
        n_chk++;
        if ({frame_start, cfg_ready, pix_x, pix_y} !== {2'b11, (X_W + Y_W)'(0)})
            $display("FAIL commit_frame: got fs=%b rdy=%b x=%0d y=%0d want 1 1 0 0", frame_start, cfg_ready, pix_x, pix_y);
        else n_pass++;
        do begin
            if (pix_y == 0 && hsync == HS_POL) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(pix_x);
            end
            if (visible) vis_all++;
            step();
            period++;
        end while (!frame_start && period <= 2 * DEF_FRAME);
        n_chk++;
        if (period != 800 * 12) $display("FAIL new_frame_period: got %0d want %0d", period, 800 * 12);
        else n_pass++;
        n_chk++;
        if (hs_low != 96 || hs_first != 656) $display("FAIL new_hsync: got width %0d start %0d want 96 656", hs_low, hs_first);
        else n_pass++;
        n_chk++;
        if (vis_all != 640 * 8) $display("FAIL new_visible: got %0d want %0d", vis_all, 640 * 8);
        else n_pass++;
        n_chk++;
        if (mism != 0) $display("FAIL trace_cfg: %0d cycles differ, first got %h want %h", mism, first_got, first_want);
        else n_pass++;
    endtask

    task automatic test_cfg_reject();
        mism = 0;
        for (int i = 0; i < 6; i++) begin
            cfg_hs_start = 11'($urandom_range(1, 1500));
            cfg_hs_end   = (i == 0) ? cfg_hs_start : 11'($urandom_range(0, int'(cfg_hs_start)));
            cfg_h_active = 11'($urandom_range(0, int'(cfg_hs_start)));
            cfg_h_total  = 11'($urandom_range(1600, 2047));
            cfg_v_active = 10'd100; cfg_v_total = 10'd200; cfg_vs_start = 10'd150; cfg_vs_end = 10'd160;
            cfg_valid = 1'b1;
            step();
            cfg_valid = 1'b0;
            n_chk++;
            if (cfg_err !== 1'b1 || cfg_ready !== 1'b1)
                $display("FAIL reject_pulse[%0d]: got err=%b rdy=%b want 1 1", i, cfg_err, cfg_ready);
            else n_pass++;
            step();
            n_chk++;
            if (cfg_err !== 1'b0) $display("FAIL reject_one_cycle[%0d]: got err=%b want 0", i, cfg_err);
            else n_pass++;
        end
        n_chk++;
        if (mism != 0) $display("FAIL trace_reject: %0d cycles differ, first got %h want %h", mism, first_got, first_want);
        else n_pass++;
    endtask

    task automatic test_en_hold();
        int spins, bad;
        spins = 0; bad = 0;
        mism = 0;
        while (pix_x !== 11'd500 && spins < 4000) begin
            step();
            spins++;
        end
        n_chk++;
        if (pix_x !== 11'd500) $display("FAIL en_reach_500: got %0d want 500", pix_x);
        else n_pass++;
        en = 1'b0;
        repeat (50) begin
            step();
            if (pix_x !== 11'd500 || visible !== 1'b0 || hsync !== !HS_POL || vsync !== !VS_POL ||
                line_start !== 1'b0 || frame_start !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL en_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        en = 1'b1;
        step();
        n_chk++;
        if (pix_x !== 11'd501) $display("FAIL en_resume: got %0d want 501", pix_x);
        else n_pass++;
        n_chk++;
        if (mism != 0) $display("FAIL trace_en: %0d cycles differ, first got %h want %h", mism, first_got, first_want);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int spins, hs_first, line_len;
        spins = 0; hs_first = -1; line_len = 0;
        mism = 0;
        while (!(pix_y == 10'd9 && line_start) && spins < 20000) begin
            step();
            spins++;
        end
        cfg_h_active = 11'd100; cfg_h_total = 11'd120; cfg_hs_start = 11'd104; cfg_hs_end = 11'd110;
        cfg_v_active = 10'd5;   cfg_v_total = 10'd8;   cfg_vs_start = 10'd6;   cfg_vs_end = 10'd7;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        n_chk++;
        if (cfg_ready !== 1'b0) $display("FAIL mid_cfg_pending: got rdy=%b want 0", cfg_ready);
        else n_pass++;
        spins = 0;
        while (!(pix_y == 10'd10 && line_start) && spins < 20000) begin
            step();
            spins++;
        end
        n_chk++;
        if (pix_y !== 10'd10) $display("FAIL mid_reach_line: got y=%0d want 10", pix_y);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({pix_x, pix_y, hsync, vsync, visible, line_start, frame_start, cfg_ready, cfg_err} !==
            {(X_W + Y_W)'(0), !HS_POL, !VS_POL, 3'b000, 1'b1, 1'b0})
            $display("FAIL mid_reset_async: got x=%0d y=%0d hs=%b vs=%b vis=%b ls=%b fs=%b rdy=%b err=%b",
                     pix_x, pix_y, hsync, vsync, visible, line_start, frame_start, cfg_ready, cfg_err);
        else n_pass++;
        model_reset();
        step();
        reset = 1'b0;
        step();
        n_chk++;
        if ({frame_start, pix_x, pix_y} !== {1'b1, (X_W + Y_W)'(0)})
            $display("FAIL mid_release: got fs=%b x=%0d y=%0d want 1 0 0", frame_start, pix_x, pix_y);
        else n_pass++;
        do begin
            if (hsync == HS_POL && hs_first < 0) hs_first = int'(pix_x);
            step();
            line_len++;
        end while (!line_start && line_len < 4000);
        n_chk++;
        if (line_len != 1328 || hs_first != 1048)
            $display("FAIL mid_defaults: got line %0d hs_start %0d want 1328 1048", line_len, hs_first);
        else n_pass++;
        n_chk++;
        if (mism != 0) $display("FAIL trace_reset_mid: %0d cycles differ, first got %h want %h", mism, first_got, first_want);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_cfg_mid_frame();
        test_cfg_reject();
        test_en_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
